arp_request_ctrl: RTL and testbench

ARP initiator that pairs with the ARP responder logic. On a resolve request from the IP transmit path it triggers an ARP request frame to a target IP. It then waits for the matching ARP reply, validated by FCS, and returns the resolved MAC. Timeout and retry are bounded. Sits between the IP TX scheduler, the ARP frame builder (TX) and the ARP parser/CRC checker (RX).

---
 rtl/arp_request_ctrl.sv | 266 ++++++++++++++++++++++++++
 tb/tb_arp_request_ctrl.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/arp_request_ctrl.sv
// arp_request_ctrl: ARP initiator. Resolves an IPv4 address to a MAC by asking
// the TX builder for an ARP request, then accepting the first matching reply
// whose FCS is good. Each attempt has a bounded wait, and the number of
// attempts is bounded.
//
// Ports:
//   aclk, aresetn             clock, asynchronous active-low reset
//   resolve_req/resolve_ip    resolve request from the IP TX scheduler (taken in IDLE only)
//   resolve_busy              high whenever the controller is not IDLE
//   resolve_done/resolve_fail one-cycle result pulses; resolve_mac holds the last result
//   arp_req_start/arp_req_tip request to the ARP TX builder; arp_req_done when sent
//   arp_reply_done, rp_*      parsed ARP reply fields from the RX parser
//   crc_valid/crc_error       FCS verdict for the current RX frame
//
// Build option: define ARP_REQ_CACHE_EN to add a single-entry aged cache that
// answers repeat resolves without sending a request.
module arp_request_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES   = 12500000,
  parameter int unsigned MAX_RETRIES      = 3,
  parameter int unsigned CACHE_AGE_CYCLES = 125000000
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic        resolve_req,
  input  logic [31:0] resolve_ip,
  output logic        resolve_busy,
  output logic        resolve_done,
  output logic        resolve_fail,
  output logic [47:0] resolve_mac,
  output logic        arp_req_start,
  output logic [31:0] arp_req_tip,
  input  logic        arp_req_done,
  input  logic        arp_reply_done,
  input  logic [31:0] rp_ip_s_addr,
  input  logic [47:0] rp_mac_s_addr,
  input  logic        crc_valid,
  input  logic        crc_error
);

  localparam int unsigned TMR_W = $clog2(TIMEOUT_CYCLES);
  localparam int unsigned RTY_W = 4;

  // Reject unusable parameterisations at elaboration.
  if (TIMEOUT_CYCLES < 4 || MAX_RETRIES < 1 || MAX_RETRIES > 15 || CACHE_AGE_CYCLES < 2) begin : g_bad_params
    $error("arp_request_ctrl: illegal parameter value");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEND,
    S_WAIT_TX,
    S_WAIT_REPLY,
    S_WAIT_FCS,
    S_DONE,
    S_FAIL
  } state_e;

  state_e             state_q, state_d;
  logic [TMR_W-1:0]   timer_q, timer_d;
  logic [RTY_W-1:0]   retry_q, retry_d;
  logic [31:0]        tip_q, tip_d;
  logic [47:0]        cand_q, cand_d;
  logic [47:0]        mac_q, mac_d;
  logic               start_q, start_d;
  logic               done_q, done_d;
  logic               fail_q, fail_d;
  logic               busy_q, busy_d;

  logic               timeout_c;
  logic               reply_match_c;
  logic               cache_hit_c;
  logic [47:0]        cache_mac_c;

  // State and output registers.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= S_IDLE;
      timer_q <= '0;
      retry_q <= '0;
      tip_q   <= '0;
      cand_q  <= '0;
      mac_q   <= '0;
      start_q <= 1'b0;
      done_q  <= 1'b0;
      fail_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      retry_q <= retry_d;
      tip_q   <= tip_d;
      cand_q  <= cand_d;
      mac_q   <= mac_d;
      start_q <= start_d;
      done_q  <= done_d;
      fail_q  <= fail_d;
      busy_q  <= busy_d;
    end
  end

  // Next-state and registered-output decode.
  always_comb begin
    state_d       = state_q;
    timer_d       = timer_q;
    retry_d       = retry_q;
    tip_d         = tip_q;
    cand_d        = cand_q;
    mac_d         = mac_q;
    timeout_c     = (timer_q == TMR_W'(TIMEOUT_CYCLES - 1));
    reply_match_c = arp_reply_done && (rp_ip_s_addr == tip_q);

    case (state_q)
      S_IDLE: begin
        if (resolve_req) begin
          tip_d   = resolve_ip;
          retry_d = '0;
          if (cache_hit_c) begin
            cand_d  = cache_mac_c;
            state_d = S_DONE;
          end else begin
            state_d = S_SEND;
          end
        end
      end
      S_SEND: begin
        retry_d = (retry_q == {RTY_W{1'b1}}) ? retry_q : retry_q + RTY_W'(1);
        state_d = S_WAIT_TX;
      end
      S_WAIT_TX: begin
        if (arp_req_done) begin
          timer_d = '0;
          state_d = S_WAIT_REPLY;
        end
      end
      S_WAIT_REPLY: begin
        // Timeout wins over anything arriving in the same cycle.
        if (timeout_c) begin
          state_d = (retry_q < RTY_W'(MAX_RETRIES)) ? S_SEND : S_FAIL;
        end else begin
          timer_d = timer_q + TMR_W'(1);
          if (reply_match_c) begin
            cand_d  = rp_mac_s_addr;
            state_d = S_WAIT_FCS;
          end
        end
      end
      S_WAIT_FCS: begin
        if (timeout_c) begin
          state_d = (retry_q < RTY_W'(MAX_RETRIES)) ? S_SEND : S_FAIL;
        end else begin
          timer_d = timer_q + TMR_W'(1);
          if (crc_valid) begin
            state_d = S_DONE;
          end else if (crc_error) begin
            // Bad FCS: drop the candidate but keep the attempt's timer running.
            cand_d  = '0;
            state_d = S_WAIT_REPLY;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_FAIL:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Pulses are decoded from the entered state so they coincide with DONE/FAIL.
    start_d = (state_q == S_SEND);
    done_d  = (state_d == S_DONE);
    fail_d  = (state_d == S_FAIL);
    busy_d  = (state_d != S_IDLE);
    if (done_d) begin
      mac_d = cand_d;
    end
  end

`ifdef ARP_REQ_CACHE_EN
  localparam int unsigned AGE_W = $clog2(CACHE_AGE_CYCLES);

  logic               cache_vld_q, cache_vld_d;
  logic [31:0]        cache_ip_q, cache_ip_d;
  logic [47:0]        cache_mac_q, cache_mac_d;
  logic [AGE_W-1:0]   age_q, age_d;
  logic               pend_q, pend_d;
  logic [47:0]        pend_mac_q, pend_mac_d;
  logic               age_exp_c;

  // Cache registers.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      cache_vld_q <= 1'b0;
      cache_ip_q  <= '0;
      cache_mac_q <= '0;
      age_q       <= '0;
      pend_q      <= 1'b0;
      pend_mac_q  <= '0;
    end else begin
      cache_vld_q <= cache_vld_d;
      cache_ip_q  <= cache_ip_d;
      cache_mac_q <= cache_mac_d;
      age_q       <= age_d;
      pend_q      <= pend_d;
      pend_mac_q  <= pend_mac_d;
    end
  end

  // Cache lookup, aging, refresh from FCS-good replies, fill and invalidation.
  always_comb begin
    cache_vld_d = cache_vld_q;
    cache_ip_d  = cache_ip_q;
    cache_mac_d = cache_mac_q;
    age_d       = age_q;
    pend_d      = pend_q;
    pend_mac_d  = pend_mac_q;

    age_exp_c   = cache_vld_q && (age_q == AGE_W'(CACHE_AGE_CYCLES - 1));
    cache_hit_c = cache_vld_q && !age_exp_c && (resolve_ip == cache_ip_q);
    cache_mac_c = cache_mac_q;

    if (cache_vld_q) begin
      age_d = age_q + AGE_W'(1);
    end

    // A verdict closes the pending reply; a same-cycle new reply starts the next.
    if (crc_valid || crc_error) begin
      pend_d = 1'b0;
      if (crc_valid && pend_q && cache_vld_q && !age_exp_c) begin
        cache_mac_d = pend_mac_q;
        age_d       = '0;
      end
    end
    if (arp_reply_done) begin
      pend_d     = cache_vld_q && (rp_ip_s_addr == cache_ip_q);
      pend_mac_d = rp_mac_s_addr;
    end

    if (age_exp_c) begin
      cache_vld_d = 1'b0;
      age_d       = '0;
    end

    // Fill only from a verified reply; a cache hit does not extend the lifetime.
    if (state_q == S_WAIT_FCS && state_d == S_DONE) begin
      cache_vld_d = 1'b1;
      cache_ip_d  = tip_q;
      cache_mac_d = cand_q;
      age_d       = '0;
    end

    if (state_d == S_FAIL && tip_q == cache_ip_q) begin
      cache_vld_d = 1'b0;
      age_d       = '0;
    end
  end
`else
  assign cache_hit_c = 1'b0;
  assign cache_mac_c = '0;
`endif

  assign resolve_busy  = busy_q;
  assign resolve_done  = done_q;
  assign resolve_fail  = fail_q;
  assign resolve_mac   = mac_q;
  assign arp_req_start = start_q;
  assign arp_req_tip   = tip_q;

endmodule

// File: tb/tb_arp_request_ctrl.sv
// Scoreboard bench for arp_request_ctrl: stimulus pushes expected events
// (kind, data, cycle); a negedge monitor pops and compares every output pulse.
module tb_arp_request_ctrl;

  localparam int unsigned TO  = 100;
  localparam int unsigned MR  = 3;
  localparam int unsigned AGE = 200;

  localparam int K_START = 0;
  localparam int K_DONE  = 1;
  localparam int K_FAIL  = 2;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic        resolve_req = 1'b0;
  logic [31:0] resolve_ip = '0;
  logic        resolve_busy;
  logic        resolve_done;
  logic        resolve_fail;
  logic [47:0] resolve_mac;
  logic        arp_req_start;
  logic [31:0] arp_req_tip;
  logic        arp_req_done = 1'b0;
  logic        arp_reply_done = 1'b0;
  logic [31:0] rp_ip_s_addr = '0;
  logic [47:0] rp_mac_s_addr = '0;
  logic        crc_valid = 1'b0;
  logic        crc_error = 1'b0;

  typedef struct {
    int          kind;
    logic [47:0] data;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   compared = 0;
  int   mismatched = 0;
  int   cyc = 0;

  arp_request_ctrl #(
    .TIMEOUT_CYCLES  (TO),
    .MAX_RETRIES     (MR),
    .CACHE_AGE_CYCLES(AGE)
  ) dut (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .resolve_req   (resolve_req),
    .resolve_ip    (resolve_ip),
    .resolve_busy  (resolve_busy),
    .resolve_done  (resolve_done),
    .resolve_fail  (resolve_fail),
    .resolve_mac   (resolve_mac),
    .arp_req_start (arp_req_start),
    .arp_req_tip   (arp_req_tip),
    .arp_req_done  (arp_req_done),
    .arp_reply_done(arp_reply_done),
    .rp_ip_s_addr  (rp_ip_s_addr),
    .rp_mac_s_addr (rp_mac_s_addr),
    .crc_valid     (crc_valid),
    .crc_error     (crc_error)
  );

  always #4 aclk = ~aclk;
  always @(posedge aclk) cyc <= cyc + 1;

  function automatic string kname(input int k);
    case (k)
      K_START: return "arp_req_start";
      K_DONE:  return "resolve_done";
      default: return "resolve_fail";
    endcase
  endfunction

  task automatic sb_check(input int kind, input logic [47:0] data);
    exp_t e;
    compared++;
    if (sb.size() == 0) begin
      mismatched++;
      $display("FAIL unexpected_%s: got data=%h at cycle %0d, required no event", kname(kind), data, cyc);
    end else begin
      e = sb.pop_front();
      if (e.kind != kind || e.data != data || e.cyc != cyc) begin
        mismatched++;
        $display("FAIL %s: got %s data=%h cycle=%0d, required %s data=%h cycle=%0d",
                 kname(e.kind), kname(kind), data, cyc, kname(e.kind), e.data, e.cyc);
      end
    end
  endtask

  // Monitor: every pulse the DUT presents is checked against the scoreboard.
  always @(negedge aclk) begin
    if (aresetn) begin
      if (arp_req_start) sb_check(K_START, {16'h0, arp_req_tip});
      if (resolve_done)  sb_check(K_DONE, resolve_mac);
      if (resolve_fail)  sb_check(K_FAIL, resolve_mac);
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic expect_ev(input int kind, input logic [47:0] data, input int at);
    exp_t e;
    e.kind = kind;
    e.data = data;
    e.cyc  = at;
    sb.push_back(e);
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) tick();
  endtask

  task automatic req(input logic [31:0] ip);
    resolve_req = 1'b1;
    resolve_ip  = ip;
    tick();
    resolve_req = 1'b0;
  endtask

  task automatic ack();
    arp_req_done = 1'b1;
    tick();
    arp_req_done = 1'b0;
  endtask

  task automatic reply(input logic [31:0] ip, input logic [47:0] mac, input logic with_crc);
    arp_reply_done = 1'b1;
    rp_ip_s_addr   = ip;
    rp_mac_s_addr  = mac;
    crc_valid      = with_crc;
    tick();
    arp_reply_done = 1'b0;
    crc_valid      = 1'b0;
  endtask

  task automatic crc(input logic good);
    crc_valid = good;
    crc_error = !good;
    tick();
    crc_valid = 1'b0;
    crc_error = 1'b0;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_busy"},  64'(resolve_busy),  64'h0);
    check({tag, "_done"},  64'(resolve_done),  64'h0);
    check({tag, "_fail"},  64'(resolve_fail),  64'h0);
    check({tag, "_start"}, 64'(arp_req_start), 64'h0);
    check({tag, "_mac"},   64'(resolve_mac),   64'h0);
    check({tag, "_tip"},   64'(arp_req_tip),   64'h0);
  endtask

  localparam logic [31:0] IP_A   = 32'hC0A8_0178;
  localparam logic [47:0] MAC_A  = 48'h84A0_DAB8_3142;
  localparam logic [31:0] IP_B   = 32'hC0A8_0199;
  localparam logic [31:0] IP_C   = 32'hC0A8_0105;
  localparam logic [47:0] MAC_C1 = 48'h1122_3344_5566;
  localparam logic [47:0] MAC_C2 = 48'h02AA_BBCC_DDEE;
  localparam logic [31:0] IP_D   = 32'hC0A8_0177;
  localparam logic [31:0] IP_E   = 32'hC0A8_0150;
  localparam logic [47:0] MAC_F2 = 48'h0200_0000_00F2;

  initial begin
    int c;

    // Reset state.
    tick();
    tick();
    check_idle_outputs("reset");
    aresetn = 1'b1;
    tick();

    // Basic resolve; a resolve_req while busy must be ignored.
    c = cyc;
    expect_ev(K_START, {16'h0, IP_A}, c + 2);
    expect_ev(K_DONE, MAC_A, c + 6);
    req(IP_A);
    wait_until(c + 2);
    ack();
    req(IP_B);
    check("busy_tip", 64'(arp_req_tip), 64'(IP_A));
    check("busy_flag", 64'(resolve_busy), 64'h1);
    reply(IP_A, MAC_A, 1'b0);
    crc(1'b1);
    wait_until(c + 10);
    check("basic_mac_held", 64'(resolve_mac), 64'(MAC_A));
    check("basic_idle", 64'(resolve_busy), 64'h0);

    // Timeout and retry: three requests, then fail with the MAC unchanged.
    c = cyc;
    expect_ev(K_START, {16'h0, IP_B}, c + 2);
    expect_ev(K_START, {16'h0, IP_B}, c + 104);
    expect_ev(K_START, {16'h0, IP_B}, c + 206);
    expect_ev(K_FAIL, MAC_A, c + 307);
    req(IP_B);
    for (int k = 0; k < 3; k++) begin
      wait_until(c + 2 + 102 * k);
      ack();
    end
    wait_until(c + 320);
    check("retry_idle", 64'(resolve_busy), 64'h0);
    check("retry_mac", 64'(resolve_mac), 64'(MAC_A));

    // Filtering: foreign reply, stray crc, crc_error, then the good reply.
    c = cyc;
    expect_ev(K_START, {16'h0, IP_C}, c + 2);
    expect_ev(K_DONE, MAC_C2, c + 14);
    req(IP_C);
    wait_until(c + 2);
    ack();
    wait_until(c + 5);
    reply(32'hC0A8_0101, 48'h0000_DEAD_BEEF, 1'b0);
    crc(1'b1);
    wait_until(c + 8);
    reply(IP_C, MAC_C1, 1'b1);
    wait_until(c + 10);
    crc(1'b0);
    wait_until(c + 12);
    reply(IP_C, MAC_C2, 1'b0);
    crc(1'b1);
    wait_until(c + 20);
    check("filter_mac", 64'(resolve_mac), 64'(MAC_C2));

    // Timeout priority: crc_valid lands in the final attempt's timeout cycle.
    c = cyc;
    expect_ev(K_START, {16'h0, IP_D}, c + 2);
    expect_ev(K_START, {16'h0, IP_D}, c + 104);
    expect_ev(K_START, {16'h0, IP_D}, c + 206);
    expect_ev(K_FAIL, MAC_C2, c + 307);
    req(IP_D);
    for (int k = 0; k < 3; k++) begin
      wait_until(c + 2 + 102 * k);
      ack();
    end
    wait_until(c + 305);
    reply(IP_D, 48'h0A0B_0C0D_0E0F, 1'b0);
    crc(1'b1);
    wait_until(c + 320);
    check("prio_mac", 64'(resolve_mac), 64'(MAC_C2));

    // Reset in WAIT_REPLY: outputs clear at once, stray traffic is ignored.
    c = cyc;
    expect_ev(K_START, {16'h0, IP_E}, c + 2);
    req(IP_E);
    wait_until(c + 2);
    ack();
    wait_until(c + 20);
    #2;
    aresetn = 1'b0;
    #1;
    check_idle_outputs("midreset");
    tick();
    tick();
    aresetn = 1'b1;
    tick();
    ack();
    reply(IP_E, 48'h0E0E_0E0E_0E0E, 1'b0);
    crc(1'b1);
    tick();
    tick();
    check("post_reset_busy", 64'(resolve_busy), 64'h0);
    check("post_reset_mac", 64'(resolve_mac), 64'h0);

    // Repeat resolve of one IP.
    c = cyc;
    expect_ev(K_START, {16'h0, IP_A}, c + 2);
    expect_ev(K_DONE, MAC_A, c + 6);
    req(IP_A);
    wait_until(c + 2);
    ack();
    wait_until(c + 4);
    reply(IP_A, MAC_A, 1'b0);
    crc(1'b1);
    wait_until(c + 10);
    c = cyc;
`ifdef ARP_REQ_CACHE_EN
    // Hit: done one cycle after the request, no frame sent.
    expect_ev(K_DONE, MAC_A, c + 1);
    req(IP_A);
    wait_until(c + 5);
    check("hit_mac", 64'(resolve_mac), 64'(MAC_A));
    // After the entry ages out a request goes on the wire again.
    wait_until(c + int'(AGE) + 20);
    c = cyc;
`endif
    expect_ev(K_START, {16'h0, IP_A}, c + 2);
    expect_ev(K_DONE, MAC_F2, c + 6);
    req(IP_A);
    wait_until(c + 2);
    ack();
    wait_until(c + 4);
    reply(IP_A, MAC_F2, 1'b0);
    crc(1'b1);
    wait_until(c + 12);
    check("repeat_mac", 64'(resolve_mac), 64'(MAC_F2));

    // Any expected event never seen is a miss.
    while (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      compared++;
      mismatched++;
      $display("FAIL missing_%s: got no event, required data=%h cycle=%0d", kname(e.kind), e.data, e.cyc);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
